// File: rtl/dht11_reader.sv
// DHT11 single-wire read sequencer: start pulse, response handshake, 40-bit capture.
// Define DHT11_CHECKSUM_EN to verify byte 4 against the sum of bytes 0..3.
module dht11_reader #(
  parameter int TICK_DIV   = 50,
  parameter int START_US   = 18000,
  parameter int BIT1_US    = 40,
  parameter int TIMEOUT_US = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       dq_in,
  output logic       dq_oe,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [1:0] err_code,
  output logic [7:0] hum_int,
  output logic [7:0] hum_dec,
  output logic [7:0] tmp_int,
  output logic [7:0] tmp_dec,
  output logic [3:0] state_dbg
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [3:0] {
    IDLE, START_LOW, WAIT_RESP, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH, CHECK, DONE
  } state_t;

  state_t        state, state_n;
  logic [PW-1:0] presc;
  logic          tick;
  logic [15:0]   us_cnt;
  logic [5:0]    bit_cnt;
  logic          dq_s1, dq_s2, dq_s3;
  logic          fall, rise, tmo, bit_val, shift_en;
  logic [31:0]   data_sr;
  logic          fin_err;
  logic [1:0]    fin_code;

`ifdef DHT11_CHECKSUM_EN
  logic [7:0] ck_sr;
  logic [7:0] ck_sum;
  assign ck_sum = data_sr[31:24] + data_sr[23:16] + data_sr[15:8] + data_sr[7:0];
`endif

  assign tick    = (presc == PW'(TICK_DIV - 1));
  assign fall    = dq_s3 & ~dq_s2;
  assign rise    = ~dq_s3 & dq_s2;
  assign tmo     = (us_cnt > 16'(TIMEOUT_US));
  assign bit_val = (us_cnt > 16'(BIT1_US));

  // start is a request accepted only in IDLE; while busy=1 further start pulses are dropped.
  assign dq_oe     = (state == START_LOW);
  assign busy      = (state != IDLE) && (state != DONE);
  assign done      = (state == DONE);
  assign state_dbg = state;

  always_comb begin
    state_n  = state;
    shift_en = 1'b0;
    fin_err  = 1'b0;
    fin_code = 2'd0;
    case (state)
      IDLE:      if (start) state_n = START_LOW;
      START_LOW: if (us_cnt == 16'(START_US)) state_n = WAIT_RESP;
      WAIT_RESP, RESP_LOW, RESP_HIGH: begin
        if ((state == RESP_LOW) ? rise : fall)
          state_n = (state == WAIT_RESP) ? RESP_LOW :
                    (state == RESP_LOW)  ? RESP_HIGH : BIT_LOW;
        else if (tmo) begin
          state_n  = DONE;
          fin_err  = 1'b1;
          fin_code = 2'd1;
        end
      end
      BIT_LOW: begin
        if (rise) state_n = BIT_HIGH;
        else if (tmo) begin
          state_n  = DONE;
          fin_err  = 1'b1;
          fin_code = 2'd3;
        end
      end
      BIT_HIGH: begin
        if (fall) begin
          shift_en = 1'b1;
          state_n  = (bit_cnt == 6'd39) ? CHECK : BIT_LOW;
        end else if (tmo) begin
          state_n  = DONE;
          fin_err  = 1'b1;
          fin_code = 2'd3;
        end
      end
      CHECK: begin
        state_n = DONE;
`ifdef DHT11_CHECKSUM_EN
        if (ck_sum != ck_sr) begin
          fin_err  = 1'b1;
          fin_code = 2'd2;
        end
`endif
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      presc    <= '0;
      us_cnt   <= '0;
      bit_cnt  <= '0;
      {dq_s3, dq_s2, dq_s1} <= 3'b111;
      data_sr  <= '0;
      err      <= 1'b0;
      err_code <= 2'd0;
      {hum_int, hum_dec, tmp_int, tmp_dec} <= '0;
`ifdef DHT11_CHECKSUM_EN
      ck_sr    <= '0;
`endif
    end else begin
      state <= state_n;
      {dq_s3, dq_s2, dq_s1} <= {dq_s2, dq_s1, dq_in};
      presc <= tick ? '0 : presc + PW'(1);
      if (state_n != state) us_cnt <= '0;
      else if (tick && us_cnt != 16'hFFFF) us_cnt <= us_cnt + 16'd1;
      if (state == IDLE && state_n == START_LOW) bit_cnt <= '0;
      else if (shift_en) bit_cnt <= bit_cnt + 6'd1;
      // The first 32 bits are the data bytes; the remaining 8 form the checksum.
      if (shift_en && bit_cnt < 6'd32) data_sr <= {data_sr[30:0], bit_val};
`ifdef DHT11_CHECKSUM_EN
      if (shift_en && bit_cnt >= 6'd32) ck_sr <= {ck_sr[6:0], bit_val};
`endif
      if (state_n == DONE && state != DONE) begin
        err      <= fin_err;
        err_code <= fin_code;
        if (!fin_err) {hum_int, hum_dec, tmp_int, tmp_dec} <= data_sr;
      end
    end
  end

endmodule

// File: tb/tb_dht11_reader.sv
// Bench for dht11_reader: open-drain sensor model, randomized frames, scoreboard of expected results.
`timescale 1ns/1ps
module tb_dht11_reader;
  localparam int TD = 4;
  localparam int SU = 20;
  localparam int B1 = 10;
  localparam int TO = 40;

  logic       clk = 1'b0;
  logic       reset, start, s_low;
  logic       dq_in, dq_oe, busy, done, err;
  logic [1:0] err_code;
  logic [7:0] hum_int, hum_dec, tmp_int, tmp_dec;
  logic [3:0] state_dbg;

  int n_chk = 0;
  int n_pass = 0;
  int done_cnt = 0;
  int busy_gap = 0;
  bit txn_active = 1'b0;
  logic [31:0] last_good = '0;
  logic [34:0] exp_q[$];

  assign dq_in = ~(dq_oe | s_low);

  always #10 clk = ~clk;

  dht11_reader #(.TICK_DIV(TD), .START_US(SU), .BIT1_US(B1), .TIMEOUT_US(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .dq_in(dq_in), .dq_oe(dq_oe),
    .busy(busy), .done(done), .err(err), .err_code(err_code),
    .hum_int(hum_int), .hum_dec(hum_dec), .tmp_int(tmp_int), .tmp_dec(tmp_dec),
    .state_dbg(state_dbg)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_chk++;
    if (obs === expv) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
  endtask

  task automatic us(input int n);
    repeat (n * TD) @(negedge clk);
  endtask

  // Reference: a frame yields its first four bytes unless the checksum rule rejects it.
  function automatic logic [34:0] predict(input logic [39:0] f);
`ifdef DHT11_CHECKSUM_EN
    logic [7:0] s;
    s = f[39:32] + f[31:24] + f[23:16] + f[15:8];
    if (s != f[7:0]) return {1'b1, 2'd2, last_good};
`endif
    last_good = f[39:8];
    return {1'b0, 2'd0, f[39:8]};
  endfunction

  function automatic logic [39:0] rand_frame();
    logic [7:0] b0, b1, b2, b3, cs;
    b0 = 8'($urandom); b1 = 8'($urandom); b2 = 8'($urandom); b3 = 8'($urandom);
    cs = b0 + b1 + b2 + b3;
    return {b0, b1, b2, b3, cs};
  endfunction

  // mode: 0 normal read, 1 silent sensor, 2 stall at bit 12, 3 reset during bit 7
  task automatic run_read(input logic [39:0] f, input int mode);
    int oe_cycles, wait_cyc, done0;
    done0 = done_cnt;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("oe_after_start", dq_oe, 1);
    txn_active = 1'b1;
    case (mode)
      0: exp_q.push_back(predict(f));
      1: exp_q.push_back({1'b1, 2'd1, last_good});
      2: exp_q.push_back({1'b1, 2'd3, last_good});
      default: ;
    endcase
    oe_cycles = 1;
    while (dq_oe && oe_cycles < SU * TD + 3 * TD) begin
      @(negedge clk);
      if (dq_oe) oe_cycles++;
    end
    chk("start_low_len", (oe_cycles >= SU * TD - TD) && (oe_cycles <= SU * TD + TD), 1);
    if (mode == 1) begin
      wait_cyc = 0;
      while (!done && wait_cyc < 100 * TD) begin
        @(negedge clk);
        wait_cyc++;
      end
      chk("noresp_latency", (wait_cyc >= TO * TD) && (wait_cyc <= (TO + 2) * TD), 1);
    end else begin
      us(2); s_low = 1'b1; us(10); s_low = 1'b0; us(10);
      for (int i = 0; i < 40; i++) begin
        s_low = 1'b1;
        us($urandom_range(8, 5));
        s_low = 1'b0;
        if (mode == 2 && i == 12) break;
        if (mode == 3 && i == 7) begin
          us(2);
          reset = 1'b1;
          @(negedge clk);
          chk("rst_oe", dq_oe, 0);
          chk("rst_busy", busy, 0);
          chk("rst_data", {hum_int, hum_dec, tmp_int, tmp_dec}, 0);
          reset = 1'b0;
          txn_active = 1'b0;
          last_good = '0;
          us(3);
          chk("rst_no_done", done_cnt - done0, 0);
          return;
        end
        if (mode == 2 && i == 5) begin
          start = 1'b1; @(negedge clk); start = 1'b0;
        end
        us(f[39 - i] ? $urandom_range(B1 + 8, B1 + 3) : $urandom_range(B1 - 3, 2));
      end
      if (mode == 0) begin
        s_low = 1'b1; us(4); s_low = 1'b0;
      end
    end
    wait_cyc = 0;
    while (done_cnt == done0 && wait_cyc < 200 * TD) begin
      @(negedge clk);
      wait_cyc++;
    end
    us(3);
    chk("single_done", done_cnt - done0, 1);
  endtask

  initial begin
    #(2_000_000);
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; start = 1'b0; s_low = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_dq_oe", dq_oe, 0);
    chk("rst_busy0", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_err_code", err_code, 0);
    chk("rst_bytes", {hum_int, hum_dec, tmp_int, tmp_dec}, 0);
    reset = 1'b0;

    fork
      forever begin
        @(negedge clk);
        if (!reset) begin
          if (txn_active && !busy && !done) busy_gap++;
          if (done) begin
            done_cnt++;
            chk("busy_at_done", busy, 0);
            chk("done_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
              logic [34:0] e;
              e = exp_q.pop_front();
              chk("err", err, e[34]);
              chk("err_code", err_code, e[33:32]);
              chk("data", {hum_int, hum_dec, tmp_int, tmp_dec}, e[31:0]);
            end
            chk("busy_held", busy_gap, 0);
            busy_gap = 0;
            txn_active = 1'b0;
          end
        end
      end
    join_none

    us(3);
    run_read(40'h37_00_18_05_54, 0);
    for (int k = 0; k < 3; k++) run_read(rand_frame(), 0);
    run_read(40'h37_00_18_05_55, 0);
    run_read(rand_frame(), 1);
    run_read(rand_frame(), 2);
    run_read(rand_frame(), 0);
    run_read(rand_frame(), 3);
    run_read(rand_frame(), 0);
    us(5);
    chk("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
